// File: rtl/bcd_race_timer.sv
// N-digit BCD race/score timer with snapshot register and multiplexed seven-segment scan driver.
// Define BCD_RACE_TIMER_LZB_EN to blank leading zeros above the decimal-point digit.

module bcd_race_timer_digit (
    input  logic       down,
    input  logic       cin,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       at_lim
);
    always_comb begin
        at_lim = down ? (d == 4'd0) : (d == 4'd9);
        q      = d;
        if (cin) begin
            if (down) q = at_lim ? 4'd9 : d - 4'd1;
            else      q = at_lim ? 4'd0 : d + 4'd1;
        end
    end
endmodule

module bcd_race_timer #(
    parameter int DIGITS    = 6,
    parameter int TICK_DIV  = 10000000,
    parameter int WRAP      = 0,
    parameter int SCAN_BITS = 16,
    parameter int DP_POS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  mode_down,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  refresh_tick,
    output logic [4*DIGITS-1:0]   bcd_live,
    output logic [4*DIGITS-1:0]   bcd_snap,
    output logic                  count_tick,
    output logic                  expired,
    output logic                  overflow,
    output logic [DIGITS-1:0]     sseg_an,
    output logic [7:0]            sseg_cat
);
    localparam int              PW      = $clog2(TICK_DIV);
    localparam int              IW      = $clog2(DIGITS);
    localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0]   IDX_TOP = IW'(DIGITS - 1);

    logic [DIGITS-1:0][3:0] live_q, snap_q, live_nxt, ld_clamp;
    logic [DIGITS-1:0]      lim, cin, dp_on;
    logic [PW-1:0]          presc;
    logic                   at_limit, stall, ps_wrap, step, zero_hit;

    // Carry/borrow into digit i is the AND of all lower digits sitting at their limit.
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign cin[i]      = &(lim | ~DIGITS'((1 << i) - 1));
        assign ld_clamp[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        assign dp_on[i]    = (i == DP_POS);
        bcd_race_timer_digit u_dig (
            .down   (mode_down),
            .cin    (cin[i]),
            .d      (live_q[i]),
            .q      (live_nxt[i]),
            .at_lim (lim[i])
        );
    end

    assign at_limit = &lim;
    assign stall    = mode_down && expired && (WRAP == 0);
    assign ps_wrap  = (presc == PS_LAST);
    assign zero_hit = run && mode_down && at_limit && !expired;
    assign step     = run && !stall && ps_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            live_q     <= '0;
            count_tick <= 1'b0;
            expired    <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            presc      <= '0;
            live_q     <= '0;
            count_tick <= 1'b0;
            expired    <= 1'b0;
            overflow   <= 1'b0;
        end else if (load) begin
            presc      <= '0;
            live_q     <= ld_clamp;
            count_tick <= 1'b0;
            expired    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count_tick <= 1'b0;
            overflow   <= 1'b0;
            if (run && !stall) presc <= ps_wrap ? '0 : presc + 1'b1;
            // Down-counting from zero that was never flagged expires without stepping.
            if (zero_hit) begin
                expired <= 1'b1;
            end else if (step && (!at_limit || WRAP != 0)) begin
                live_q     <= live_nxt;
                count_tick <= 1'b1;
                overflow   <= at_limit && !mode_down;
                if (mode_down && live_nxt == '0) expired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            snap_q <= '0;
        else if (refresh_tick) snap_q <= live_q;
    end

    assign bcd_live = live_q;
    assign bcd_snap = snap_q;

    logic [SCAN_BITS-1:0] scan_cnt;
    logic [IW-1:0]        idx;
    logic [3:0]           cur;
    logic [6:0]           seg;
    logic                 guard, blank;

    assign cur   = snap_q[idx];
    assign guard = (scan_cnt[SCAN_BITS-1 -: 2] == 2'b11);

    always_comb begin
        case (cur)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

`ifdef BCD_RACE_TIMER_LZB_EN
    logic [DIGITS-1:0] zd, lzb;
    // Digit i is a leading zero when it and every higher digit are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lzb
        assign zd[i]  = (snap_q[i] == 4'd0);
        assign lzb[i] = (i > DP_POS) && (&(zd | DIGITS'((1 << i) - 1)));
    end
    assign blank = lzb[idx];
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            idx      <= IDX_TOP;
            sseg_an  <= '1;
            sseg_cat <= 8'hFF;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) idx <= (idx == '0) ? IDX_TOP : idx - 1'b1;
            sseg_an  <= ~(DIGITS'(1) << idx);
            sseg_cat <= guard ? {~dp_on[idx], blank ? 7'h7F : seg} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_bcd_race_timer.sv
// Bench for bcd_race_timer: WRAP=0 and WRAP=1 instances share stimulus; integer-level model plus directed tables.
module tb_bcd_race_timer;
    localparam int D  = 4;
    localparam int DP = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0, run = 1'b0, mode_down = 1'b0, load = 1'b0, refresh_tick = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] live [2];
    logic [15:0] snap [2];
    logic        tick [2], expd [2], ovf [2];
    logic [3:0]  an [2];
    logic [7:0]  cat [2];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar w = 0; w < 2; w++) begin : g_dut
        bcd_race_timer #(.DIGITS(D), .TICK_DIV(4), .WRAP(w), .SCAN_BITS(3), .DP_POS(DP)) u_dut (
            .clk(clk), .reset(reset), .clear(clear), .run(run), .mode_down(mode_down),
            .load(load), .load_val(load_val), .refresh_tick(refresh_tick),
            .bcd_live(live[w]), .bcd_snap(snap[w]), .count_tick(tick[w]),
            .expired(expd[w]), .overflow(ovf[w]), .sseg_an(an[w]), .sseg_cat(cat[w]));
    end

    always #5 clk = ~clk;

    task automatic chk(string nm, int w, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0h want %0h", nm, w, $time, act, exp);
        end
    endtask

    function automatic int p10(int d);
        int r = 1;
        for (int k = 0; k < d; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] seg7(int dig);
        case (dig)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int d = 0; d < D; d++) r[4*d +: 4] = 4'((v / p10(d)) % 10);
        return r;
    endfunction

    function automatic int clamp(logic [15:0] lv);
        int v = 0;
        for (int d = 0; d < D; d++) begin
            int n = int'(lv[4*d +: 4]);
            if (n > 9) n = 9;
            v += n * p10(d);
        end
        return v;
    endfunction

    function automatic logic [7:0] disp(int v, int d);
        logic [6:0] s = seg7((v / p10(d)) % 10);
`ifdef BCD_RACE_TIMER_LZB_EN
        if (d > DP && v < p10(d)) s = 7'h7F;
`endif
        return {(d == DP) ? 1'b0 : 1'b1, s};
    endfunction

    // Reference model: counter value held as a plain integer 0..9999.
    int         m_val [2], m_psc [2], m_snap [2];
    bit         m_exp [2], m_tick [2], m_ovf [2];
    int         m_sc, m_idx;
    logic [3:0] m_an;
    logic [7:0] m_cat [2];

    task automatic count_model(int w);
        bit stp = 1'b0;
        if (refresh_tick) m_snap[w] = m_val[w];
        if (clear || load) begin
            m_val[w] = clear ? 0 : clamp(load_val);
            m_psc[w] = 0; m_exp[w] = 0; m_tick[w] = 0; m_ovf[w] = 0;
        end else begin
            m_tick[w] = 0; m_ovf[w] = 0;
            if (run && !(mode_down && m_exp[w] && w == 0)) begin
                m_psc[w]++;
                if (m_psc[w] == 4) begin m_psc[w] = 0; stp = 1'b1; end
            end
            if (run && mode_down && m_val[w] == 0 && !m_exp[w]) m_exp[w] = 1;
            else if (stp && !mode_down) begin
                if (m_val[w] < 9999) begin m_val[w]++; m_tick[w] = 1; end
                else if (w == 1) begin m_val[w] = 0; m_tick[w] = 1; m_ovf[w] = 1; end
            end else if (stp) begin
                if (m_val[w] > 0) begin
                    m_val[w]--; m_tick[w] = 1;
                    if (m_val[w] == 0) m_exp[w] = 1;
                end else begin
                    m_val[w] = 9999; m_tick[w] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < 2; w++) begin
                m_val[w] = 0; m_psc[w] = 0; m_snap[w] = 0;
                m_exp[w] = 0; m_tick[w] = 0; m_ovf[w] = 0; m_cat[w] = 8'hFF;
            end
            m_sc = 0; m_idx = D - 1; m_an = 4'hF;
        end else begin
            m_an = ~(4'b0001 << m_idx);
            for (int w = 0; w < 2; w++) m_cat[w] = (m_sc >= 6) ? disp(m_snap[w], m_idx) : 8'hFF;
            if (m_sc == 7) m_idx = (m_idx == 0) ? D - 1 : m_idx - 1;
            m_sc = (m_sc + 1) % 8;
            for (int w = 0; w < 2; w++) count_model(w);
        end
    end

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            chk("m_live", w, 32'(live[w]), 32'(to_bcd(m_val[w])));
            chk("m_snap", w, 32'(snap[w]), 32'(to_bcd(m_snap[w])));
            chk("m_flags", w, 32'({expd[w], ovf[w], tick[w]}), 32'({m_exp[w], m_ovf[w], m_tick[w]}));
            chk("m_an", w, 32'(an[w]), 32'(m_an));
            chk("m_cat", w, 32'(cat[w]), 32'(m_cat[w]));
        end
    end

    typedef struct {
        bit          run, md, clr, ld;
        logic [15:0] lv;
        int          n;
        logic [15:0] l0, l1;
        logic [2:0]  f0, f1;   // {expired, overflow, count_tick}
    } vec_t;

    function automatic vec_t mk(bit r, bit md, bit c, bit l, logic [15:0] lv, int n,
                                logic [15:0] l0, logic [15:0] l1, logic [2:0] f0, logic [2:0] f1);
        vec_t t;
        t.run = r; t.md = md; t.clr = c; t.ld = l; t.lv = lv; t.n = n;
        t.l0 = l0; t.l1 = l1; t.f0 = f0; t.f1 = f1;
        return t;
    endfunction

    initial begin
        vec_t       tbl [20];
        int         on [2][4];
        int         tot [2][4];
        logic [7:0] seen [2][4];
        logic [7:0] ev [4];
        int         ev_on [4];

        tbl[0]  = mk(0, 0, 0, 1, 16'h0009, 1,  16'h0009, 16'h0009, 3'b000, 3'b000);
        tbl[1]  = mk(1, 0, 0, 0, 16'h0000, 4,  16'h0010, 16'h0010, 3'b001, 3'b001);
        tbl[2]  = mk(0, 0, 0, 1, 16'h0098, 1,  16'h0098, 16'h0098, 3'b000, 3'b000);
        tbl[3]  = mk(1, 0, 0, 0, 16'h0000, 4,  16'h0099, 16'h0099, 3'b001, 3'b001);
        tbl[4]  = mk(1, 0, 0, 0, 16'h0000, 4,  16'h0100, 16'h0100, 3'b001, 3'b001);
        tbl[5]  = mk(1, 0, 0, 0, 16'h0000, 2,  16'h0100, 16'h0100, 3'b000, 3'b000);
        tbl[6]  = mk(0, 0, 0, 0, 16'h0000, 7,  16'h0100, 16'h0100, 3'b000, 3'b000);
        tbl[7]  = mk(1, 0, 0, 0, 16'h0000, 1,  16'h0100, 16'h0100, 3'b000, 3'b000);
        tbl[8]  = mk(1, 0, 0, 0, 16'h0000, 1,  16'h0101, 16'h0101, 3'b001, 3'b001);
        tbl[9]  = mk(0, 0, 0, 1, 16'h9998, 1,  16'h9998, 16'h9998, 3'b000, 3'b000);
        tbl[10] = mk(1, 0, 0, 0, 16'h0000, 4,  16'h9999, 16'h9999, 3'b001, 3'b001);
        tbl[11] = mk(1, 0, 0, 0, 16'h0000, 4,  16'h9999, 16'h0000, 3'b000, 3'b011);
        tbl[12] = mk(0, 1, 0, 1, 16'h0002, 1,  16'h0002, 16'h0002, 3'b000, 3'b000);
        tbl[13] = mk(1, 1, 0, 0, 16'h0000, 4,  16'h0001, 16'h0001, 3'b001, 3'b001);
        tbl[14] = mk(1, 1, 0, 0, 16'h0000, 4,  16'h0000, 16'h0000, 3'b101, 3'b101);
        tbl[15] = mk(1, 1, 0, 0, 16'h0000, 20, 16'h0000, 16'h9995, 3'b100, 3'b101);
        tbl[16] = mk(1, 1, 1, 0, 16'h0000, 1,  16'h0000, 16'h0000, 3'b000, 3'b000);
        tbl[17] = mk(1, 1, 0, 0, 16'h0000, 1,  16'h0000, 16'h0000, 3'b100, 3'b100);
        tbl[18] = mk(0, 0, 1, 1, 16'h5555, 1,  16'h0000, 16'h0000, 3'b000, 3'b000);
        tbl[19] = mk(0, 0, 0, 1, 16'hF9A3, 1,  16'h9993, 16'h9993, 3'b000, 3'b000);

        #12;
        for (int w = 0; w < 2; w++) begin
            chk("rst_live", w, 32'(live[w]), 32'h0);
            chk("rst_an", w, 32'(an[w]), 32'hF);
            chk("rst_cat", w, 32'(cat[w]), 32'hFF);
        end
        #11 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run = tbl[i].run; mode_down = tbl[i].md; clear = tbl[i].clr;
            load = tbl[i].ld; load_val = tbl[i].lv;
            repeat (tbl[i].n) @(negedge clk);
            chk($sformatf("tbl%0d_live", i), 0, 32'(live[0]), 32'(tbl[i].l0));
            chk($sformatf("tbl%0d_live", i), 1, 32'(live[1]), 32'(tbl[i].l1));
            chk($sformatf("tbl%0d_flags", i), 0, 32'({expd[0], ovf[0], tick[0]}), 32'(tbl[i].f0));
            chk($sformatf("tbl%0d_flags", i), 1, 32'({expd[1], ovf[1], tick[1]}), 32'(tbl[i].f1));
        end

        // Asynchronous reset between clock edges while counting.
        run = 1'b0; mode_down = 1'b0; clear = 1'b0; load = 1'b1; load_val = 16'h0042;
        @(negedge clk); load = 1'b0; refresh_tick = 1'b1; run = 1'b1;
        @(negedge clk); refresh_tick = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #2 reset = 1'b0; #1;
        for (int w = 0; w < 2; w++) begin
            chk("arst_live", w, 32'(live[w]), 32'h0);
            chk("arst_snap", w, 32'(snap[w]), 32'h0);
            chk("arst_flags", w, 32'({expd[w], ovf[w], tick[w]}), 32'h0);
            chk("arst_an", w, 32'(an[w]), 32'hF);
            chk("arst_cat", w, 32'(cat[w]), 32'hFF);
        end
        @(negedge clk); #3 reset = 1'b1;

        // Display: snapshot 0123, then live changes without touching the snapshot.
        @(negedge clk); run = 1'b0; load = 1'b1; load_val = 16'h0123;
        @(negedge clk); load = 1'b0; refresh_tick = 1'b1;
        @(negedge clk); refresh_tick = 1'b0; load = 1'b1; load_val = 16'h0777;
        @(negedge clk); load = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk("snap_hold", w, 32'(snap[w]), 32'h0123);
            chk("live_after_ld", w, 32'(live[w]), 32'h0777);
        end
        ev[0] = 8'hB0; ev[1] = 8'h24; ev[2] = 8'hF9; ev[3] = 8'hC0;
        ev_on[0] = 2; ev_on[1] = 2; ev_on[2] = 2;
`ifdef BCD_RACE_TIMER_LZB_EN
        ev_on[3] = 0;
`else
        ev_on[3] = 2;
`endif
        for (int w = 0; w < 2; w++)
            for (int d = 0; d < 4; d++) begin on[w][d] = 0; tot[w][d] = 0; seen[w][d] = 8'hFF; end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++)
                for (int d = 0; d < 4; d++)
                    if (!an[w][d]) begin
                        tot[w][d]++;
                        if (cat[w] != 8'hFF) begin on[w][d]++; seen[w][d] = cat[w]; end
                    end
        end
        for (int w = 0; w < 2; w++)
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("slot%0d_cycles", d), w, 32'(tot[w][d]), 32'd8);
                chk($sformatf("slot%0d_lit", d), w, 32'(on[w][d]), 32'(ev_on[d]));
                if (ev_on[d] > 0) chk($sformatf("slot%0d_cat", d), w, 32'(seen[w][d]), 32'(ev[d]));
            end

        // Randomised traffic against the model, with boundary-biased preset values.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            run          = ($urandom_range(0, 9) != 0);
            clear        = ($urandom_range(0, 119) == 0);
            load         = ($urandom_range(0, 59) == 0);
            refresh_tick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) mode_down = ~mode_down;
            case ($urandom_range(0, 3))
                0:       load_val = 16'h0001;
                1:       load_val = 16'h9998;
                2:       load_val = 16'h0000;
                default: load_val = 16'($urandom);
            endcase
        end
        @(negedge clk);
        run = 1'b0; clear = 1'b0; load = 1'b0; refresh_tick = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
